mem_load_unit: RTL and testbench
================================

# mem_load_unit

Load-side counterpart of the store data encoder in the CPU memory stage. Accepts a load request from the pipeline and issues a word-aligned read to data memory over a req/ack handshake. It then extracts the addressed byte or halfword from the returned word using the same lane placement the store path writes, zero- or sign-extends it, and presents the result with a one-cycle valid pulse. It stalls the pipeline while the access is outstanding.

## Interface
Parameters: none.

Ports:
- clk  input  1  core clock; the block uses one clock.
- rst  input  1  reset; synchronous and active-high.
- memRead  input  1  load request; sampled only when the block is not busy.
- addr  input  32  byte address of the load.
- dataSize  input  2  access size: 0 = word, 1 = halfword, 2 = byte, 3 = illegal.
- loadUnsigned  input  1  1 = zero-extend, 0 = sign-extend. Ignored for word loads.
- memReq  output  1  read request to memory.
- memAddr  output  32  word address, {addr[31:2], 2'b00}, latched at acceptance.
- memAck  input  1  memory ack; memRData is valid in the same cycle.
- memRData  input  32  read word from memory.
- outData  output  32  extended load result (registered).
- valid  output  1  one-cycle pulse marking outData as new.
- stall  output  1  pipeline hold.
- fault  output  1  misaligned or illegal access pulse. Present only with LOAD_FAULT_EN.

## Operation
The FSM has three states: IDLE, REQ and DONE.

- **Acceptance.** A request is accepted in IDLE or DONE when memRead=1. The block latches addr[1:0] as the offset, plus dataSize, loadUnsigned and memAddr.
- **Legality.** An access is legal for:
  - a word load at offset 0 only;
  - a halfword load at offset 0 or 2;
  - a byte load at any offset.
  - Anything else is illegal, including dataSize=3.
- **Transitions.**
  - IDLE/DONE -> REQ on a legal memRead.
  - IDLE/DONE -> DONE on an illegal memRead. No memory request is made.
  - REQ -> DONE when memAck=1. The extracted and extended memRData is registered into outData.
  - DONE -> IDLE when memRead=0.
- **Lane mapping.** This mirrors the store encoder. Byte at offset 0 = memRData[31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]. Halfword at offset 0 = [31:16], offset 2 = [15:0]. Word = [31:0].
- **Extension.** Sign extension replicates bit 7 (byte) or bit 15 (halfword) into the upper bits. Zero extension fills them with 0.
- **Illegal access.** outData = 0 and valid pulses in DONE.
- **memReq.** memReq=1 exactly while in REQ. memAddr is stable throughout REQ.
- **memAck outside REQ.** Ignored.
- **Reset.** rst at any clock edge forces IDLE. Mid-transaction this drops memReq the following cycle and discards any in-flight ack.

## Timing
- **Reset values:** memReq=0, memAddr=0, outData=0, valid=0, fault=0, stall=0.
- **stall (combinational):**
  - 1 in REQ;
  - 1 in IDLE/DONE while a legal memRead is presented;
  - 0 otherwise.
  - An illegal request does not stall.
- **Latency.** Request accepted at edge 0 gives memReq=1 in cycle 1. If memAck arrives in cycle k (k≥1), valid=1 in cycle k+1 and stall=0 in that cycle. The minimum is 2 cycles from memRead to valid.
- **Back-to-back loads.** A new memRead presented during DONE is accepted in the same cycle, giving one load per 2 cycles at zero wait states.
- **Held data.** outData holds its value until the next completion.

## Configuration
LOAD_FAULT_EN:
- **Defined.**
  - The fault port exists.
  - fault pulses high together with valid for an illegal access; it stays 0 for legal accesses.
- **Undefined.**
  - There is no fault port.
  - An illegal access still completes silently with outData=0 and a valid pulse.

## Structure
- **Shared package mem_access_pkg.**
  - dataSize encodings SIZE_WORD=0, SIZE_HALF=1, SIZE_BYTE=2. These are shared with the store encoder.
  - Load FSM state encoding.
- **Sub-module load_data_extract.** Combinational: inputs (word, offset, dataSize, loadUnsigned), outputs (extended result, legal flag). It is instantiated once and also drives the legality check at acceptance.

## Test plan
- **Signed byte.** Byte load, addr=0x1001, signed; memRData=0x12F45678 -> memAddr=0x1000, outData=0xFFFFFFF4, valid 2 cycles after memRead with an ack in cycle 1.
- **Unsigned halfword.** Halfword load, addr=0x2002, unsigned; memRData=0xAAAA8001 -> outData=0x00008001. Same data signed -> 0xFFFF8001.
- **Wait states.** Word load with memAck delayed 3 cycles -> memReq and stall held for 3 cycles, memAddr stable, outData=memRData, a single valid pulse.
- **Illegal access.** Halfword at offset 1, and dataSize=3 -> memReq never asserted, outData=0, valid pulse next cycle. fault=1 only with LOAD_FAULT_EN.
- **Back-to-back.** Loads to 0x10 (byte 3) and 0x14 (word), zero-wait acks -> two valid pulses 2 cycles apart with correct data.
- **Reset mid-transaction.** rst asserted in REQ -> next cycle all outputs are 0. A late memAck is ignored with no valid pulse.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared memory-stage encodings: access-size codes (common with the store
// encoder) and the load FSM state type.
package mem_access_pkg;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_REQ  = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/load_data_extract.sv
// Combinational lane select + zero/sign extension for loads, plus the
// legality flag for (offset, size). Lane order matches the store encoder.
module load_data_extract
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o,
  output logic        legal_o
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    half    = offset_i[1] ? word_i[15:0] : word_i[31:16];
    byte_v  = word_i[31:24];
    data_o  = '0;
    legal_o = 1'b0;
    case (offset_i)
      2'd0:    byte_v = word_i[31:24];
      2'd1:    byte_v = word_i[23:16];
      2'd2:    byte_v = word_i[15:8];
      default: byte_v = word_i[7:0];
    endcase
    case (size_i)
      SIZE_WORD: begin
        legal_o = (offset_i == 2'd0);
        data_o  = word_i;
      end
      SIZE_HALF: begin
        legal_o = ~offset_i[0];
        data_o  = {{16{~unsigned_i & half[15]}}, half};
      end
      SIZE_BYTE: begin
        legal_o = 1'b1;
        data_o  = {{24{~unsigned_i & byte_v[7]}}, byte_v};
      end
      default: ;
    endcase
    // Illegal accesses always return zero
    if (!legal_o) data_o = '0;
  end

endmodule

// File: rtl/mem_load_unit.sv
// Load unit: word-aligned req/ack read, lane extract, one-cycle valid pulse.
// Optional LOAD_FAULT_EN adds a fault pulse for misaligned/illegal loads.
module mem_load_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic [31:0] addr,
  input  logic [1:0]  dataSize,
  input  logic        loadUnsigned,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memRData,
  output logic [31:0] outData,
  output logic        valid,
  output logic        stall
`ifdef LOAD_FAULT_EN
  ,output logic       fault
`endif
);

  ld_state_e   state_q, state_d;
  logic [1:0]  off_q, size_q;
  logic        uns_q;
  logic [31:0] addr_q, out_q;
  logic        valid_q;
  logic        accept;

  logic [1:0]  x_off, x_size;
  logic        x_uns, x_legal;
  logic [31:0] x_data;

  // One extractor: fed by the incoming request while idle (legality check),
  // by the latched request while waiting for the ack.
  always_comb begin
    x_off  = addr[1:0];
    x_size = dataSize;
    x_uns  = loadUnsigned;
    if (state_q == LD_REQ) begin
      x_off  = off_q;
      x_size = size_q;
      x_uns  = uns_q;
    end
  end

  load_data_extract u_extract (
    .word_i     (memRData),
    .offset_i   (x_off),
    .size_i     (x_size),
    .unsigned_i (x_uns),
    .data_o     (x_data),
    .legal_o    (x_legal)
  );

  assign accept = (state_q != LD_REQ) && memRead;

  always_ff @(posedge clk) begin
    if (rst) state_q <= LD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE, LD_DONE: begin
        if (memRead)                state_d = x_legal ? LD_REQ : LD_DONE;
        else if (state_q == LD_DONE) state_d = LD_IDLE;
      end
      LD_REQ:  if (memAck) state_d = LD_DONE;
      default: state_d = LD_IDLE;
    endcase
  end

  always_comb begin
    memReq = (state_q == LD_REQ);
    stall  = (state_q == LD_REQ) || (accept && x_legal);
  end

`ifdef LOAD_FAULT_EN
  logic fault_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
`ifdef LOAD_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef LOAD_FAULT_EN
      fault_q <= 1'b0;
`endif
      if (accept) begin
        off_q  <= addr[1:0];
        size_q <= dataSize;
        uns_q  <= loadUnsigned;
        addr_q <= {addr[31:2], 2'b00};
        if (!x_legal) begin
          out_q   <= '0;
          valid_q <= 1'b1;
`ifdef LOAD_FAULT_EN
          fault_q <= 1'b1;
`endif
        end
      end else if (state_q == LD_REQ && memAck) begin
        out_q   <= x_data;
        valid_q <= 1'b1;
      end
    end
  end

  assign memAddr = addr_q;
  assign outData = out_q;
  assign valid   = valid_q;
`ifdef LOAD_FAULT_EN
  assign fault   = fault_q;
`endif

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit with a transaction-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_mem_load_unit;

  logic        clk = 1'b0;
  logic        rst, memRead, loadUnsigned, memAck;
  logic [31:0] addr, memRData;
  logic [1:0]  dataSize;
  logic        memReq, valid, stall;
  logic [31:0] memAddr, outData;
`ifdef LOAD_FAULT_EN
  logic        fault;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mem_load_unit dut (
    .clk(clk), .rst(rst), .memRead(memRead), .addr(addr), .dataSize(dataSize),
    .loadUnsigned(loadUnsigned), .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memRData(memRData), .outData(outData), .valid(valid),
    .stall(stall)
`ifdef LOAD_FAULT_EN
    , .fault(fault)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd0) return off == 2'd0;
    if (sz == 2'd1) return off[0] == 1'b0;
    return sz == 2'd2;
  endfunction

  // Byte lanes counted from the top of the word: offset 0 is the MSB lane.
  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] off,
                                         input logic [1:0] sz, input logic u);
    int nb;
    logic [31:0] v;
    if (!m_legal(sz, off)) return 32'h0;
    if (sz == 2'd0) return w;
    nb = (sz == 2'd1) ? 2 : 1;
    v = w >> (8 * (4 - nb - int'(off)));
    if (nb == 1) begin
      v = v & 32'hFF;
      if (!u && v[7]) v = v | 32'hFFFFFF00;
    end else begin
      v = v & 32'hFFFF;
      if (!u && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  // Model: a load is either outstanding or not; IDLE and DONE look the same.
  bit          m_pend = 1'b0, m_valid = 1'b0, m_fault = 1'b0, m_u = 1'b0;
  logic [31:0] m_addr = '0, m_out = '0;
  logic [1:0]  m_off = '0, m_sz = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_valid = 0; m_fault = 0; m_addr = '0; m_out = '0;
    end else begin
      m_valid = 0; m_fault = 0;
      if (!m_pend && memRead) begin
        m_addr = {addr[31:2], 2'b00};
        if (m_legal(dataSize, addr[1:0])) begin
          m_pend = 1; m_off = addr[1:0]; m_sz = dataSize; m_u = loadUnsigned;
        end else begin
          m_out = '0; m_valid = 1; m_fault = 1;
        end
      end else if (m_pend && memAck) begin
        m_out = m_load(memRData, m_off, m_sz, m_u);
        m_valid = 1; m_pend = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_memReq", 32'(memReq), 32'(m_pend));
      chk("cyc_memAddr", memAddr, m_addr);
      chk("cyc_valid", 32'(valid), 32'(m_valid));
      chk("cyc_outData", outData, m_out);
      chk("cyc_stall", 32'(stall),
          32'(m_pend || (memRead && m_legal(dataSize, addr[1:0]))));
`ifdef LOAD_FAULT_EN
      chk("cyc_fault", 32'(fault), 32'(m_fault));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Accept, wait 'waits' cycles in REQ, then ack; checks the result cycle.
  task automatic load(input string nm, input logic [31:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] rd, input int waits,
                      input logic [31:0] exp);
    memRead = 1; addr = a; dataSize = sz; loadUnsigned = u; memAck = 0;
    #1 chk({nm, "_stall_acc"}, 32'(stall), 32'd1);
    cyc();
    memRead = 0;
    chk({nm, "_memAddr"}, memAddr, {a[31:2], 2'b00});
    for (int i = 0; i < waits; i++) begin
      memRData = $urandom;
      #1 chk({nm, "_req_wait"}, 32'(memReq), 32'd1);
      cyc();
    end
    memAck = 1; memRData = rd;
    cyc();
    memAck = 0;
    chk({nm, "_valid"}, 32'(valid), 32'd1);
    chk({nm, "_data"}, outData, exp);
    chk({nm, "_stall_done"}, 32'(stall), 32'd0);
    cyc();
    chk({nm, "_pulse"}, 32'(valid), 32'd0);
  endtask

  task automatic illegal(input string nm, input logic [31:0] a, input logic [1:0] sz);
    memRead = 1; addr = a; dataSize = sz; loadUnsigned = 0;
    #1 chk({nm, "_nostall"}, 32'(stall), 32'd0);
    cyc();
    memRead = 0;
    chk({nm, "_noreq"}, 32'(memReq), 32'd0);
    chk({nm, "_valid"}, 32'(valid), 32'd1);
    chk({nm, "_data"}, outData, 32'h0);
`ifdef LOAD_FAULT_EN
    chk({nm, "_fault"}, 32'(fault), 32'd1);
`endif
    cyc();
    chk({nm, "_pulse"}, 32'(valid), 32'd0);
  endtask

  initial begin
    rst = 1; memRead = 0; addr = '0; dataSize = '0; loadUnsigned = 0;
    memAck = 0; memRData = '0;
    cyc();
    cmp_en = 1;
    cyc();
    rst = 0;
    #1;
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_memAddr", memAddr, 32'h0);
    chk("rst_outData", outData, 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    cyc();

    load("sbyte", 32'h1001, 2'd2, 1'b0, 32'h12F45678, 0, 32'hFFFFFFF4);
    load("uhalf", 32'h2002, 2'd1, 1'b1, 32'hAAAA8001, 0, 32'h00008001);
    load("shalf", 32'h2002, 2'd1, 1'b0, 32'hAAAA8001, 0, 32'hFFFF8001);
    load("word_ws", 32'h3000, 2'd0, 1'b0, 32'h89ABCDEF, 3, 32'h89ABCDEF);
    load("ubyte0", 32'h0, 2'd2, 1'b1, 32'h80112233, 1, 32'h00000080);
    load("shalf0", 32'h40, 2'd1, 1'b0, 32'h7FFF0000, 0, 32'h00007FFF);

    illegal("ill_half1", 32'h2001, 2'd1);
    illegal("ill_size3", 32'h3000, 2'd3);
    illegal("ill_word2", 32'h3002, 2'd0);

    // Back-to-back: second load presented while the first is in flight
    memRead = 1; addr = 32'h13; dataSize = 2'd2; loadUnsigned = 1;
    cyc();
    addr = 32'h14; dataSize = 2'd0; memAck = 1; memRData = 32'h11223344;
    cyc();
    chk("b2b_v1", 32'(valid), 32'd1);
    chk("b2b_d1", outData, 32'h00000044);
    memRData = 32'h55555555;
    cyc();
    memRead = 0; memRData = 32'hCAFEF00D;
    chk("b2b_gap", 32'(valid), 32'd0);
    chk("b2b_addr2", memAddr, 32'h14);
    cyc();
    memAck = 0;
    chk("b2b_v2", 32'(valid), 32'd1);
    chk("b2b_d2", outData, 32'hCAFEF00D);
    cyc();

    // Reset while the request is outstanding, then a late ack
    memRead = 1; addr = 32'h80; dataSize = 2'd0; loadUnsigned = 0;
    cyc();
    memRead = 0;
    chk("rmid_req", 32'(memReq), 32'd1);
    rst = 1;
    cyc();
    rst = 0;
    chk("rmid_memReq", 32'(memReq), 32'd0);
    chk("rmid_memAddr", memAddr, 32'h0);
    chk("rmid_outData", outData, 32'h0);
    chk("rmid_valid", 32'(valid), 32'd0);
    chk("rmid_stall", 32'(stall), 32'd0);
    memAck = 1; memRData = 32'hDEADBEEF;
    cyc();
    memAck = 0;
    chk("rmid_lateack", 32'(valid), 32'd0);
    chk("rmid_hold", outData, 32'h0);
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
